instruction_fetch_buffered: RTL and testbench

- Parametrised successor to the single-PC fetch stage.
- Holds a fetch PC and drives the instruction memory address.
- Pushes {instruction, pc} pairs into a small prefetch FIFO so fetch keeps running while decode is stalled.
- Flushes the FIFO and redirects on a taken branch from execute; feeds the IF/ID boundary with a valid-qualified packet.

---
 rtl/instruction_fetch_buffered_pkg.sv | 20 ++
 rtl/instruction_fetch_buffered_if.sv | 43 ++++
 rtl/instruction_fetch_buffered_fetch_fifo.sv | 50 +++++
 rtl/instruction_fetch_buffered.sv | 76 +++++++
 tb/tb_instruction_fetch_buffered.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_buffered_pkg.sv
// Shared constants for the fetch stage and its consumers (decode reuses the
// default widths and the IF packet field offsets).
package instruction_fetch_buffered_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 16;

    // IF packet layout: {instruction, pc}, pc in the low bits.
    localparam int PC_LSB = 0;

    function automatic int instr_lsb(input int addr_w);
        return addr_w;
    endfunction

    // Branch bus is {taken, target}; taken sits just above the target field.
    function automatic int taken_bit(input int addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffered_if.sv
// Fetch-stage bus: branch redirect and stall in, instruction memory port,
// and the valid-qualified IF/ID packet out.
interface instruction_fetch_buffered_if
    import instruction_fetch_buffered_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Handshake: if_valid is the producer's valid, !data_stall is the
    // consumer's ready; a packet transfers in any cycle where both hold and
    // no taken branch is present. if_output is stable while valid && !ready.
    logic [ADDR_W:0]              branch_update_with_isbranch;
    logic                         data_stall;
    logic [ADDR_W-1:0]            imem_addr;
    logic [INSTR_W-1:0]           imem_rdata;
    logic                         if_valid;
    logic [ADDR_W+INSTR_W-1:0]    if_output;
    logic [CNT_W-1:0]             fifo_count;

    modport master (
        input  branch_update_with_isbranch,
        input  data_stall,
        input  imem_rdata,
        output imem_addr,
        output if_valid,
        output if_output,
        output fifo_count
    );

    modport slave (
        output branch_update_with_isbranch,
        output data_stall,
        output imem_rdata,
        input  imem_addr,
        input  if_valid,
        input  if_output,
        input  fifo_count
    );

endinterface

// File: rtl/instruction_fetch_buffered_fetch_fifo.sv
// Prefetch FIFO with synchronous flush; head data is gated to zero when empty
// so the IF/ID packet never carries stale contents.
module fetch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               wdata,
    output logic [WIDTH-1:0]               rdata,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem[wr_ptr] <= wdata;
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_buffered.sv
// Buffered fetch stage: PC register, memory address, push/pop/flush control
// around a prefetch FIFO feeding the IF/ID boundary.
module instruction_fetch_buffered
    import instruction_fetch_buffered_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 1,
    parameter int RESET_PC = 0
) (
    input logic                          clk,
    input logic                          rst,
    instruction_fetch_buffered_if.master bus
);
    localparam int PKT_W     = ADDR_W + INSTR_W;
    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int INSTR_LSB = instr_lsb(ADDR_W);
    localparam int TAKEN_BIT = taken_bit(ADDR_W);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PKT_W-1:0]  wdata;
    logic [PKT_W-1:0]  rdata;
    logic [CNT_W-1:0]  count;

    assign taken  = bus.branch_update_with_isbranch[TAKEN_BIT];
    assign target = bus.branch_update_with_isbranch[ADDR_W-1:0];

    // A taken branch discards everything in flight, so it blocks both ends.
    assign pop  = !fifo_empty && !bus.data_stall && !taken;
    assign push = (!fifo_full || pop) && !taken;

    always_comb begin
        wdata = '0;
        wdata[PC_LSB +: ADDR_W]     = fetch_pc;
        wdata[INSTR_LSB +: INSTR_W] = bus.imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= ADDR_W'(RESET_PC);
        end else if (taken) begin
            fetch_pc <= target;
        end else if (push) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    fetch_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (taken),
        .wdata (wdata),
        .rdata (rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    assign bus.imem_addr  = fetch_pc;
    assign bus.if_valid   = !fifo_empty;
    assign bus.if_output  = rdata;
    assign bus.fifo_count = count;

endmodule

// File: tb/tb_instruction_fetch_buffered.sv
// Directed bench for the buffered fetch stage: stimulus tasks push expected
// packets, negedge monitors pop and compare every accepted packet.
module tb_instruction_fetch_buffered;

    logic clk;
    logic rst;
    logic rst2;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp2_q[$];

    instruction_fetch_buffered_if #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) bus ();
    instruction_fetch_buffered_if #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) bus2 ();

    instruction_fetch_buffered #(
        .ADDR_W(8), .INSTR_W(16), .DEPTH(4), .PC_STEP(1), .RESET_PC(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instruction_fetch_buffered #(
        .ADDR_W(8), .INSTR_W(16), .DEPTH(4), .PC_STEP(1), .RESET_PC(8'hFE)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    // Instruction memory model: word at address a reads 0xA000 | a.
    assign bus.imem_rdata  = 16'hA000 | {8'h00, bus.imem_addr};
    assign bus2.imem_rdata = 16'hA000 | {8'h00, bus2.imem_addr};

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- helpers ----------------
    function automatic logic [23:0] pkt(input logic [7:0] p);
        logic [15:0] instr;
        instr = 16'hA000 | {8'h00, p};
        return {instr, p};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_stall = 1'b0;
        bus.branch_update_with_isbranch = '0;
        step();
        rst = 1'b0;
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!rst && bus.if_valid && !bus.data_stall && !bus.branch_update_with_isbranch[8]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pkt unexpected actual=%0h expected=none", bus.if_output);
            end else begin
                check("pkt", {8'h00, bus.if_output}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && bus2.if_valid && !bus2.data_stall && !bus2.branch_update_with_isbranch[8]) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pkt2 unexpected actual=%0h expected=none", bus2.if_output);
            end else begin
                check("pkt2", {8'h00, bus2.if_output}, {8'h00, exp2_q.pop_front()});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.data_stall = 1'b0;
        bus.branch_update_with_isbranch = '0;
        bus2.data_stall = 1'b0;
        bus2.branch_update_with_isbranch = '0;
        step();

        // Reset state
        do_reset();
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_output", {8'h00, bus.if_output}, 32'd0);
        check("rst_addr", {24'b0, bus.imem_addr}, 32'd0);
        check("rst_count", {29'b0, bus.fifo_count}, 32'd0);

        // Free running: pc 0..4 accepted on consecutive cycles
        for (int i = 0; i < 5; i++) exp_q.push_back(pkt(8'(i)));
        step();
        check("a_valid1", {31'b0, bus.if_valid}, 32'd1);
        check("a_head1", {8'h00, bus.if_output}, {8'h00, pkt(8'h00)});
        for (int i = 0; i < 5; i++) step();
        check("a_drain", exp_q.size(), 32'd0);

        // Stall fills the FIFO, then a single-cycle release
        do_reset();
        bus.data_stall = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("b_count_full", {29'b0, bus.fifo_count}, 32'd4);
        check("b_addr_freeze", {24'b0, bus.imem_addr}, 32'd4);
        check("b_head0", {8'h00, bus.if_output}, {8'h00, pkt(8'h00)});
        for (int i = 0; i < 6; i++) exp_q.push_back(pkt(8'(i)));
        bus.data_stall = 1'b0;
        step();
        bus.data_stall = 1'b1;
        check("b_count_pp", {29'b0, bus.fifo_count}, 32'd4);
        check("b_addr_adv", {24'b0, bus.imem_addr}, 32'd5);
        check("b_head1", {8'h00, bus.if_output}, {8'h00, pkt(8'h01)});
        step();
        step();
        check("b_count_hold", {29'b0, bus.fifo_count}, 32'd4);
        check("b_addr_hold", {24'b0, bus.imem_addr}, 32'd5);
        bus.data_stall = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("b_drain", exp_q.size(), 32'd0);

        // Taken branch with 3 entries buffered and decode stalled
        do_reset();
        bus.data_stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("c_count3", {29'b0, bus.fifo_count}, 32'd3);
        bus.branch_update_with_isbranch = 9'h140;
        step();
        check("c_count0", {29'b0, bus.fifo_count}, 32'd0);
        check("c_valid0", {31'b0, bus.if_valid}, 32'd0);
        check("c_addr", {24'b0, bus.imem_addr}, 32'h40);
        check("c_output0", {8'h00, bus.if_output}, 32'd0);
        bus.branch_update_with_isbranch = '0;
        bus.data_stall = 1'b0;
        exp_q.push_back(pkt(8'h40));
        exp_q.push_back(pkt(8'h41));
        step();
        check("c_head40", {8'h00, bus.if_output}, {8'h00, pkt(8'h40)});
        step();
        step();
        check("c_drain", exp_q.size(), 32'd0);

        // Reset together with a taken branch: reset wins
        rst = 1'b1;
        bus.branch_update_with_isbranch = 9'h120;
        step();
        check("d_addr", {24'b0, bus.imem_addr}, 32'd0);
        check("d_count", {29'b0, bus.fifo_count}, 32'd0);
        check("d_valid", {31'b0, bus.if_valid}, 32'd0);
        rst = 1'b0;
        bus.branch_update_with_isbranch = '0;
        exp_q.push_back(pkt(8'h00));
        step();
        check("d_head0", {8'h00, bus.if_output}, {8'h00, pkt(8'h00)});
        step();
        rst = 1'b1;
        check("d_drain", exp_q.size(), 32'd0);

        // PC wrap on the second instance (RESET_PC = 0xFE)
        rst2 = 1'b0;
        exp2_q.push_back(pkt(8'hFE));
        exp2_q.push_back(pkt(8'hFF));
        exp2_q.push_back(pkt(8'h00));
        exp2_q.push_back(pkt(8'h01));
        step();
        check("e_head_fe", {8'h00, bus2.if_output}, {8'h00, pkt(8'hFE)});
        step();
        check("e_addr_wrap", {24'b0, bus2.imem_addr}, 32'h00);
        for (int i = 0; i < 3; i++) step();
        rst2 = 1'b1;
        step();
        check("e_drain", exp2_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
